// File: rtl/stat_graph_render_pkg.sv
// Shared constants and types for the stat_graph_render history-graph overlay.
// Geometry defaults live here so the top and its users agree on them.
package stat_graph_render_pkg;

   localparam int DEF_TALLY_W = 16;
   localparam int DEF_GRAPH_X = 660;
   localparam int DEF_GRAPH_Y = 40;
   localparam int DEF_GRAPH_H = 192;

   localparam logic [11:0] AXIS_COLOR = 12'hFFF;
   localparam logic [11:0] GRID_COLOR = 12'h333;

   typedef logic [DEF_TALLY_W-1:0] tally_t;

   typedef enum logic [1:0] {
      ST_ACCUM,
      ST_COMMIT,
      ST_SCAN,
      ST_SCALE
   } state_t;

endpackage

// File: rtl/stat_history.sv
// Circular per-channel sample history with valid bits, a combinational read
// port for the display, and a serial max-reduction used to pick the scale.
module stat_history
   import stat_graph_render_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int HISTORY_LEN = 32,
   parameter int TALLY_W     = DEF_TALLY_W,
   localparam int AW         = $clog2(HISTORY_LEN)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_en,
   input  logic [NUM_CH-1:0][TALLY_W-1:0] wr_data,
   output logic [AW-1:0]                  wr_ptr,
   input  logic [AW-1:0]                  rd_addr,
   output logic [NUM_CH-1:0][TALLY_W-1:0] rd_data,
   output logic                           rd_valid,
   input  logic                           scan_start,
   output logic                           scan_last,
   output logic [TALLY_W-1:0]             max_val
);

   localparam int TOTAL = NUM_CH * HISTORY_LEN;
   localparam int CW    = $clog2(TOTAL + 1);

   logic [HISTORY_LEN-1:0][NUM_CH-1:0][TALLY_W-1:0] hist;
   logic [HISTORY_LEN-1:0]                          valid;
   logic [CW-1:0]                                   scan_cnt;
   logic                                            scan_act;
   logic [AW-1:0]                                   scan_ent;
   logic [TALLY_W-1:0]                              scan_val;

   assign rd_data   = hist[rd_addr];
   assign rd_valid  = valid[rd_addr];
   assign scan_ent  = scan_cnt[AW-1:0];
   assign scan_last = scan_act && (scan_cnt == CW'(TOTAL - 1));

   // Scan order: all entries of channel 0, then channel 1, ...
   always_comb begin
      scan_val = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (int'(scan_cnt >> AW) == c) scan_val = hist[scan_ent][c];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist     <= '0;
         valid    <= '0;
         wr_ptr   <= '0;
         scan_cnt <= '0;
         scan_act <= 1'b0;
         max_val  <= '0;
      end else begin
         if (wr_en) begin
            hist[wr_ptr]  <= wr_data;
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (scan_start) begin
            scan_act <= 1'b1;
            scan_cnt <= '0;
            max_val  <= '0;
         end else if (scan_act) begin
            if (valid[scan_ent] && scan_val > max_val) max_val <= scan_val;
            scan_cnt <= scan_cnt + 1'b1;
            if (scan_last) scan_act <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/stat_graph_render.sv
// Auto-scaling multi-channel event history graph overlay (stage 2 renderer).
// Define STAT_GRAPH_GRID_EN to add four horizontal gridlines in the plot area.
module stat_graph_render
   import stat_graph_render_pkg::*;
#(
   parameter int NUM_CH         = 2,
   parameter int HISTORY_LEN    = 32,
   parameter int TALLY_W        = DEF_TALLY_W,
   parameter int SAMPLE_FRAMES  = 32,
   parameter int LOG_SAMPLE_PIX = 3,
   parameter int GRAPH_X        = DEF_GRAPH_X,
   parameter int GRAPH_Y        = DEF_GRAPH_Y,
   parameter int GRAPH_H        = DEF_GRAPH_H,
   parameter int SCREEN_W       = 1024,
   parameter int SCREEN_H       = 768,
   parameter logic [NUM_CH*12-1:0] CH_COLORS = {12'h0F0, 12'hF00}
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [10:0]       hcount_in,
   input  logic [9:0]        vcount_in,
   input  logic [NUM_CH-1:0] event_in,
   output logic [11:0]       pix_out,
   output logic [4:0]        scale_out,
   output logic              busy_out
);

   localparam int AW       = $clog2(HISTORY_LEN);
   localparam int FW       = (SAMPLE_FRAMES > 1) ? $clog2(SAMPLE_FRAMES) : 1;
   localparam int GRAPH_W  = HISTORY_LEN << LOG_SAMPLE_PIX;
   localparam int BASE_ROW = GRAPH_Y + GRAPH_H - 1;
   localparam logic [TALLY_W-1:0] SAT = '1;

   state_t                         state, state_nxt;
   logic [NUM_CH-1:0][TALLY_W-1:0] acc, rd_data;
   logic [FW-1:0]                  frame_cnt;
   logic [AW-1:0]                  wr_ptr, rd_addr;
   logic                           rd_valid, scan_last;
   logic [TALLY_W-1:0]             max_val;
   logic [4:0]                     scale_try;
   logic                           visible, frame_end, fit;
   logic                           in_px, in_py, on_yaxis, on_xaxis;
   logic [11:0]                    pix_nxt;
   int                             hc, vc;

   assign hc        = int'(hcount_in);
   assign vc        = int'(vcount_in);
   assign visible   = (hc < SCREEN_W) && (vc < SCREEN_H);
   assign frame_end = (hc == SCREEN_W - 1) && (vc == SCREEN_H - 1);
   assign fit       = ((32'(max_val) >> scale_try) < 32'(GRAPH_H));
   assign busy_out  = (state != ST_ACCUM);

   stat_history #(
      .NUM_CH      (NUM_CH),
      .HISTORY_LEN (HISTORY_LEN),
      .TALLY_W     (TALLY_W)
   ) u_hist (
      .clk        (clk_in),
      .rst_n      (rst_n_in),
      .wr_en      (state == ST_COMMIT),
      .wr_data    (acc),
      .wr_ptr     (wr_ptr),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .scan_start (state == ST_COMMIT),
      .scan_last  (scan_last),
      .max_val    (max_val)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) state <= ST_ACCUM;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ACCUM:  if (frame_end && frame_cnt == '0) state_nxt = ST_COMMIT;
         ST_COMMIT: state_nxt = ST_SCAN;
         ST_SCAN:   if (scan_last) state_nxt = ST_SCALE;
         ST_SCALE:  if (fit) state_nxt = ST_ACCUM;
         default:   state_nxt = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         acc       <= '0;
         frame_cnt <= '0;
         scale_try <= '0;
         scale_out <= '0;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (visible && frame_cnt == '0)
                  for (int c = 0; c < NUM_CH; c++)
                     if (event_in[c] && acc[c] != SAT) acc[c] <= acc[c] + 1'b1;
               if (frame_end)
                  frame_cnt <= (frame_cnt == FW'(SAMPLE_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
            end
            ST_COMMIT: begin
               acc       <= '0;
               scale_try <= '0;
            end
            // Linear search; scale_out only moves once the new value is known.
            ST_SCALE: begin
               if (fit) scale_out <= scale_try;
               else     scale_try <= scale_try + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_px    = (hc > GRAPH_X) && (hc < GRAPH_X + GRAPH_W);
   assign in_py    = (vc >= GRAPH_Y) && (vc < GRAPH_Y + GRAPH_H);
   assign on_yaxis = (hc == GRAPH_X) && (vc >= GRAPH_Y) && (vc <= GRAPH_Y + GRAPH_H);
   assign on_xaxis = (vc == GRAPH_Y + GRAPH_H) && (hc >= GRAPH_X) && (hc < GRAPH_X + GRAPH_W);
   // Offsetting by wr_ptr puts the oldest sample in the leftmost column.
   assign rd_addr  = wr_ptr + AW'((hc - GRAPH_X) >>> LOG_SAMPLE_PIX);

   always_comb begin
      pix_nxt = '0;
`ifdef STAT_GRAPH_GRID_EN
      if (in_px && in_py && ((vc - GRAPH_Y) % (GRAPH_H / 4)) == 0 &&
          ((vc - GRAPH_Y) / (GRAPH_H / 4)) < 4)
         pix_nxt = GRID_COLOR;
`endif
      for (int c = NUM_CH - 1; c >= 0; c--)
         if (in_px && in_py && rd_valid && vc == BASE_ROW - int'(rd_data[c] >> scale_out))
            pix_nxt = CH_COLORS[c*12 +: 12];
      if (on_yaxis || on_xaxis) pix_nxt = AXIS_COLOR;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) pix_out <= '0;
      else           pix_out <= pix_nxt;
   end

endmodule

// File: tb/tb_stat_graph_render.sv
// Scoreboard bench: stimulus queues expected values, a monitor checks them
// one cycle later against pix_out / scale_out / busy_out.
module tb_stat_graph_render;
   import stat_graph_render_pkg::*;

   localparam int K_PIX = 0, K_SCALE = 1, K_BUSY = 2;
   localparam int BH = 1100, BV = 770;

   typedef struct {
      int          kind;
      logic [11:0] exp;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [1:0]  events;
   logic [11:0] pix;
   logic [4:0]  scale;
   logic        busy;
   logic        probe = 1'b0;
   logic        probe_d = 1'b0;
   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   stat_graph_render #(
      .NUM_CH        (2),
      .HISTORY_LEN   (4),
      .SAMPLE_FRAMES (2)
   ) dut (
      .clk_in    (clk),
      .rst_n_in  (rst_n),
      .hcount_in (hcount),
      .vcount_in (vcount),
      .event_in  (events),
      .pix_out   (pix),
      .scale_out (scale),
      .busy_out  (busy)
   );

   initial forever begin
      @(posedge clk);
      probe_d = probe;
   end

   initial forever begin
      exp_t        e;
      logic [11:0] act;
      @(negedge clk);
      if (probe_d) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got probe with no expected entry, required one");
         end else begin
            e = q.pop_front();
            case (e.kind)
               K_PIX:   act = pix;
               K_SCALE: act = {7'b0, scale};
               default: act = {11'b0, busy};
            endcase
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s: got %h required %h", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic cyc(input int h, input int v, input logic [1:0] ev);
      @(negedge clk);
      hcount = 11'(h); vcount = 10'(v); events = ev; probe = 1'b0;
   endtask

   task automatic chk(input int h, input int v, input logic [1:0] ev,
                      input int kind, input int exp, input string nm);
      exp_t e;
      @(negedge clk);
      hcount = 11'(h); vcount = 10'(v); events = ev; probe = 1'b1;
      e.kind = kind; e.exp = 12'(exp); e.name = nm;
      q.push_back(e);
   endtask

   task automatic set_rst(input logic v);
      @(negedge clk);
      rst_n = v; probe = 1'b0;
   endtask

   // One counted frame (last pixel is the frame-end pixel) then one gated frame.
   task automatic sample(input int n0, input int n1, input int exp_scale, input string nm);
      int         nm_cyc;
      logic [1:0] ev;
      nm_cyc = (n0 > n1) ? n0 : n1;
      if (nm_cyc == 0) nm_cyc = 1;
      for (int i = 0; i < nm_cyc; i++) begin
         ev[0] = (i < n0);
         ev[1] = (i < n1);
         if (i == nm_cyc - 1) cyc(1023, 767, ev);
         else                 cyc(0, 0, ev);
      end
      chk(BH, BV, 2'b00, K_BUSY, 1, {nm, "_busy_commit"});
      repeat (3) cyc(BH, BV, 2'b00);
      chk(BH, BV, 2'b00, K_BUSY, 1, {nm, "_busy_hold"});
      repeat (30) cyc(BH, BV, 2'b00);
      chk(BH, BV, 2'b00, K_SCALE, exp_scale, {nm, "_scale"});
      repeat (50) cyc(0, 0, 2'b11);
      cyc(1023, 767, 2'b11);
      chk(BH, BV, 2'b00, K_BUSY, 0, {nm, "_busy_gated"});
   endtask

   initial begin
      rst_n = 1'b0; hcount = 11'(BH); vcount = 10'(BV); events = '0;
      repeat (2) cyc(BH, BV, 2'b00);
      set_rst(1'b1);
      // Partial sample accumulated, then wiped by a mid-frame reset.
      repeat (30) cyc(0, 0, 2'b11);
      set_rst(1'b0);
      chk(660, 100, 2'b11, K_PIX,   0, "rst_pix");
      chk(BH,  BV,  2'b11, K_SCALE, 0, "rst_scale");
      chk(BH,  BV,  2'b11, K_BUSY,  0, "rst_busy");
      set_rst(1'b1);

      chk(660, 100, 2'b00, K_PIX, 12'hFFF, "yaxis");
      chk(660, 232, 2'b00, K_PIX, 12'hFFF, "axis_corner");
      chk(660, 233, 2'b00, K_PIX, 0,       "yaxis_below");
      chk(660, 39,  2'b00, K_PIX, 0,       "yaxis_above");
      chk(691, 232, 2'b00, K_PIX, 12'hFFF, "xaxis_end");
      chk(692, 232, 2'b00, K_PIX, 0,       "xaxis_past");
      chk(670, 231, 2'b00, K_PIX, 0,       "invalid_no_point");
      chk(670, 88,  2'b00, K_PIX, 0,       "no_grid");

      sample(100, 100, 0, "s1");
      chk(688, 131, 2'b00, K_PIX, 12'hF00, "s1_point_ch0_prio");
      chk(688, 130, 2'b00, K_PIX, 0,       "s1_above_point");
      chk(680, 131, 2'b00, K_PIX, 0,       "s1_invalid_col");

      sample(1000, 30, 3, "s2");
      chk(688, 106, 2'b00, K_PIX, 12'hF00, "s2_ch0_scaled");
      chk(688, 228, 2'b00, K_PIX, 12'h0F0, "s2_ch1_scaled");
      chk(680, 219, 2'b00, K_PIX, 12'hF00, "s2_old_sample");
      chk(672, 231, 2'b00, K_PIX, 0,       "s2_invalid_col");

      sample(200, 0, 3, "s3");
      sample(400, 0, 3, "s4");
      sample(600, 0, 3, "s5");
      chk(664, 106, 2'b00, K_PIX, 12'hF00, "wrap_col0");
      chk(664, 228, 2'b00, K_PIX, 12'h0F0, "wrap_col0_ch1");
      chk(670, 206, 2'b00, K_PIX, 12'hF00, "wrap_col1");
      chk(678, 181, 2'b00, K_PIX, 12'hF00, "wrap_col2");
      chk(686, 156, 2'b00, K_PIX, 12'hF00, "wrap_col3");
      chk(686, 219, 2'b00, K_PIX, 0,       "wrap_evicted");
      chk(686, 231, 2'b00, K_PIX, 12'h0F0, "wrap_ch1_zero");

      sample(65541, 0, 9, "sat");
      chk(688, 104, 2'b00, K_PIX, 12'hF00, "sat_point");
      chk(680, 230, 2'b00, K_PIX, 12'hF00, "sat_rescaled_old");
      chk(688, 231, 2'b00, K_PIX, 12'h0F0, "sat_ch1");

      repeat (3) cyc(BH, BV, 2'b00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
